// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, funct3 codes, requester ids and alignment check for dmem_arbiter
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {REQ_CORE = 1'b0, REQ_DBG = 1'b1} req_id_t;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_W && a != 2'b00) || ((f3 == F3_H || f3 == F3_HU) && a[0]);
  endfunction
endpackage

// File: rtl/dmem_arbiter_arb2_sel.sv
// arb2_sel: one-hot two-way grant; round-robin on ties when DMEM_ARB_RR_EN is defined, else core priority
module arb2_sel
  import dmem_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);
`ifdef DMEM_ARB_RR_EN
  always_comb grant = &valid ? (last_grant == REQ_DBG ? 2'b01 : 2'b10) : valid;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  always_comb grant = valid[0] ? 2'b01 : valid;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with fixed read latency (tie policy via DMEM_ARB_RR_EN)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_valid,
  input  logic              d_req_valid,
  output logic              c_req_ready,
  output logic              d_req_ready,
  input  logic              c_req_we,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       c_req_wdata,
  input  logic [31:0]       d_req_wdata,
  input  logic [2:0]        c_req_funct3,
  input  logic [2:0]        d_req_funct3,
  output logic              c_rsp_valid,
  output logic              d_rsp_valid,
  output logic              c_rsp_err,
  output logic              d_rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);
  state_t state_q, state_d;
  req_id_t owner_q, owner_d, last_q, last_d, gid;
  logic we_q, we_d, err_q, err_d, idle, accept, issue, resp, s_we;
  logic [ADDR_W-1:0] addr_q, addr_d, s_addr;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, s_wdata;
  logic [2:0] f3_q, f3_d, cnt_q, cnt_d, s_f3;
  logic [1:0] grant;
  arb2_sel u_sel (
    .valid({d_req_valid, c_req_valid}),
    .last_grant(last_q),
    .grant(grant)
  );
  always_comb begin
    idle    = state_q == IDLE && !rst;
    issue   = state_q == ISSUE && !rst;
    resp    = state_q == RESP && !rst;
    accept  = idle && |grant;
    gid     = grant[1] ? REQ_DBG : REQ_CORE;
    s_we    = grant[1] ? d_req_we : c_req_we;
    s_addr  = grant[1] ? d_req_addr : c_req_addr;
    s_wdata = grant[1] ? d_req_wdata : c_req_wdata;
    s_f3    = grant[1] ? d_req_funct3 : c_req_funct3;
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        owner_d = gid;
        last_d  = gid;
        we_d    = s_we;
        addr_d  = s_addr;
        wdata_d = s_wdata;
        f3_d    = s_f3;
        err_d   = misaligned(s_f3, s_addr[1:0]);
        rdata_d = '0;
        state_d = err_d ? RESP : ISSUE;
      end
      ISSUE: begin
        cnt_d   = 3'(RD_LAT);
        rdata_d = (!we_q && RD_LAT == 0) ? mem_rdata : rdata_q;
        state_d = (we_q || RD_LAT == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        rdata_d = cnt_q == 3'd1 ? mem_rdata : rdata_q;
        state_d = cnt_q == 3'd1 ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= REQ_CORE;
      last_q  <= REQ_DBG;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    c_req_ready = idle && grant[0];
    d_req_ready = idle && grant[1];
    mem_wr      = issue && we_q;
    mem_rd      = issue && !we_q;
    mem_addr    = (issue || (state_q == WAIT && !rst)) ? addr_q : '0;
    mem_wdata   = issue ? wdata_q : '0;
    mem_funct3  = issue ? f3_q : '0;
    c_rsp_valid = resp && owner_q == REQ_CORE;
    d_rsp_valid = resp && owner_q == REQ_DBG;
    c_rsp_err   = c_rsp_valid && err_q;
    d_rsp_err   = d_rsp_valid && err_q;
    rsp_rdata   = resp ? rdata_q : '0;
    busy        = state_q != IDLE;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter at RD_LAT 1, 3 and 0 sharing one stimulus bus
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic c_valid = 0, d_valid = 0, c_we = 0, d_we = 0;
  logic [10:0] c_addr = '0, d_addr = '0;
  logic [31:0] c_wdata = '0, d_wdata = '0, mrdata = '0;
  logic [2:0] c_f3 = '0, d_f3 = '0;
  logic [2:0] c_rdy, d_rdy, c_rv, d_rv, c_err, d_err, mwr, mrd, bsy;
  logic [31:0] rdata [3];
  logic [31:0] mwdata [3];
  logic [10:0] maddr [3];
  logic [2:0] mf3 [3];
  int tests = 0, fails = 0, n;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(11), .RD_LAT(g == 0 ? 1 : g == 1 ? 3 : 0)) u (
      .clk(clk), .rst(rst),
      .c_req_valid(c_valid), .d_req_valid(d_valid),
      .c_req_ready(c_rdy[g]), .d_req_ready(d_rdy[g]),
      .c_req_we(c_we), .d_req_we(d_we),
      .c_req_addr(c_addr), .d_req_addr(d_addr),
      .c_req_wdata(c_wdata), .d_req_wdata(d_wdata),
      .c_req_funct3(c_f3), .d_req_funct3(d_f3),
      .c_rsp_valid(c_rv[g]), .d_rsp_valid(d_rv[g]),
      .c_rsp_err(c_err[g]), .d_rsp_err(d_err[g]),
      .rsp_rdata(rdata[g]),
      .mem_wr(mwr[g]), .mem_rd(mrd[g]),
      .mem_addr(maddr[g]), .mem_wdata(mwdata[g]), .mem_funct3(mf3[g]),
      .mem_rdata(mrdata),
      .busy(bsy[g])
    );
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    #1;
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_ready", 32'({c_rdy[0], d_rdy[0]}), 0);
    chk("rst_strobes", 32'({mwr[0], mrd[0]}), 0);
    chk("rst_rsp", 32'({c_rv[0], d_rv[0], c_err[0], d_err[0]}), 0);
    chk("rst_addr", 32'(maddr[0]), 0);
    chk("rst_rdata", rdata[0], 0);
    rst = 1'b0;
    tick();
    c_valid = 1; c_we = 0; c_addr = 11'h010; c_f3 = 3'd2;
    #1;
    chk("t1_c_ready", 32'(c_rdy[0]), 1);
    chk("t1_d_ready", 32'(d_rdy[0]), 0);
    chk("t1_rd_T", 32'(mrd[0]), 0);
    tick();
    c_valid = 0;
    #1;
    chk("t1_rd_T1", 32'(mrd[0]), 1);
    chk("t1_addr", 32'(maddr[0]), 32'h010);
    chk("t1_f3", 32'(mf3[0]), 2);
    chk("t1_busy", 32'(bsy[0]), 1);
    chk("t1_ready_busy", 32'(c_rdy[0]), 0);
    tick();
    mrdata = 32'hDEADBEEF;
    #1;
    chk("t1_rd_T2", 32'(mrd[0]), 0);
    chk("t1_rv_T2", 32'(c_rv[0]), 0);
    tick();
    mrdata = 32'h0;
    #1;
    chk("t1_rv", 32'(c_rv[0]), 1);
    chk("t1_rdata", rdata[0], 32'hDEADBEEF);
    chk("t1_err", 32'(c_err[0]), 0);
    chk("t1_d_rv", 32'(d_rv[0]), 0);
    tick();
    #1;
    chk("t1_rv_end", 32'(c_rv[0]), 0);
    chk("t1_idle", 32'(bsy[0]), 0);
    d_valid = 1; d_we = 1; d_addr = 11'h004; d_wdata = 32'h12345678; d_f3 = 3'd2;
    #1;
    chk("t2_d_ready", 32'(d_rdy[0]), 1);
    chk("t2_c_ready", 32'(c_rdy[0]), 0);
    tick();
    d_valid = 0;
    #1;
    chk("t2_wr", 32'(mwr[0]), 1);
    chk("t2_rd", 32'(mrd[0]), 0);
    chk("t2_addr", 32'(maddr[0]), 32'h004);
    chk("t2_wdata", mwdata[0], 32'h12345678);
    tick();
    #1;
    chk("t2_wr_once", 32'(mwr[0]), 0);
    chk("t2_rv", 32'(d_rv[0]), 1);
    chk("t2_c_rv", 32'(c_rv[0]), 0);
    chk("t2_rdata", rdata[0], 0);
    chk("t2_err", 32'(d_err[0]), 0);
    tick();
    c_valid = 1; d_valid = 1; c_we = 0; d_we = 0;
    c_addr = 11'h020; d_addr = 11'h024; c_f3 = 3'd2; d_f3 = 3'd2;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      chk("t3_onehot", 32'(c_rdy[0] & d_rdy[0]), 0);
`ifdef DMEM_ARB_RR_EN
      if (c_rdy[0] | d_rdy[0]) begin
        chk("t3_grant_rr", 32'(d_rdy[0]), 32'(n % 2));
        n++;
      end
`else
      chk("t3_no_dbg", 32'(d_rdy[0]), 0);
      if (c_rdy[0]) n++;
`endif
      tick();
    end
    chk("t3_count", 32'(n), 4);
    c_valid = 0; d_valid = 0;
    for (int c = 0; c < 10 && bsy[0]; c++) tick();
    #1;
    chk("t3_drain", 32'(bsy[0]), 0);
    c_valid = 1; c_we = 0; c_addr = 11'h006; c_f3 = 3'd2;
    #1;
    chk("t4w_ready", 32'(c_rdy[0]), 1);
    tick();
    c_valid = 0;
    #1;
    chk("t4w_rv", 32'(c_rv[0]), 1);
    chk("t4w_err", 32'(c_err[0]), 1);
    chk("t4w_strobes", 32'({mrd[0], mwr[0]}), 0);
    chk("t4w_rdata", rdata[0], 0);
    tick();
    #1;
    chk("t4w_idle", 32'({bsy[0], c_rv[0], mrd[0], mwr[0]}), 0);
    c_valid = 1; c_addr = 11'h003; c_f3 = 3'd1;
    #1;
    chk("t4h_ready", 32'(c_rdy[0]), 1);
    tick();
    c_valid = 0;
    #1;
    chk("t4h_rv", 32'(c_rv[0]), 1);
    chk("t4h_err", 32'(c_err[0]), 1);
    chk("t4h_strobes", 32'({mrd[0], mwr[0]}), 0);
    tick();
    #1;
    chk("t4h_idle", 32'({bsy[0], c_rv[0], mrd[0], mwr[0]}), 0);
    do_reset();
    c_valid = 1; c_we = 0; c_addr = 11'h040; c_f3 = 3'd2; mrdata = 32'h0BADF00D;
    #1;
    chk("t5_accept", 32'(c_rdy[1]), 1);
    tick();
    c_valid = 0;
    #1;
    chk("t5_rd", 32'(mrd[1]), 1);
    tick();
    tick();
    rst = 1;
    #1;
    chk("t5_rst_strobes", 32'({mrd[1], mwr[1], c_rv[1], d_rv[1]}), 0);
    tick();
    rst = 0;
    #1;
    chk("t5_idle", 32'(bsy[1]), 0);
    chk("t5_addr", 32'(maddr[1]), 0);
    chk("t5_rdata", rdata[1], 0);
    chk("t5_outs", 32'({mrd[1], mwr[1], c_rv[1], d_rv[1], c_rdy[1], d_rdy[1]}), 0);
    c_valid = 1; c_addr = 11'h044; mrdata = 32'hCAFE0044;
    #1;
    chk("t5_reaccept", 32'(c_rdy[1]), 1);
    tick();
    c_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t5_no_rsp", 32'({c_rv[1], d_rv[1]}), 0);
      tick();
    end
    #1;
    chk("t5_rv", 32'(c_rv[1]), 1);
    chk("t5_new_rdata", rdata[1], 32'hCAFE0044);
    do_reset();
    c_valid = 1; c_we = 0; c_addr = 11'h080; c_f3 = 3'd2; mrdata = 32'hA5A50001;
    #1;
    chk("t6_acc1", 32'(c_rdy[2]), 1);
    tick();
    #1;
    chk("t6_issue_ready", 32'(c_rdy[2]), 0);
    chk("t6_rd1", 32'(mrd[2]), 1);
    tick();
    #1;
    chk("t6_resp_ready", 32'(c_rdy[2]), 0);
    chk("t6_rv1", 32'(c_rv[2]), 1);
    chk("t6_rdata1", rdata[2], 32'hA5A50001);
    tick();
    mrdata = 32'h5A5A0002;
    #1;
    chk("t6_acc2", 32'(c_rdy[2]), 1);
    tick();
    #1;
    chk("t6_rd2", 32'(mrd[2]), 1);
    chk("t6_issue_ready2", 32'(c_rdy[2]), 0);
    tick();
    c_valid = 0;
    #1;
    chk("t6_rv2", 32'(c_rv[2]), 1);
    chk("t6_rdata2", rdata[2], 32'h5A5A0002);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
